// File: rtl/comparator_bist_if.sv
// Comparator-side bus between the BIST engine and the Comparator4bit under test.
// The engine drives the operands (master); the comparator returns its three flags (slave).
interface comparator_bist_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] dut_in0;
    logic [WIDTH-1:0] dut_in1;
    logic             dut_greater;
    logic             dut_smaller;
    logic             dut_equal;

    modport master (
        output dut_in0,
        output dut_in1,
        input  dut_greater,
        input  dut_smaller,
        input  dut_equal
    );

    modport slave (
        input  dut_in0,
        input  dut_in1,
        output dut_greater,
        output dut_smaller,
        output dut_equal
    );
endinterface

// File: rtl/comparator_bist.sv
// Self-test engine for the Comparator4bit magnitude comparator: sweeps every operand
// pair, checks greater/smaller/equal and reports pass, error count and first failure.
module comparator_bist #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    comparator_bist_if.master  cmp,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_count,
    output logic [WIDTH-1:0]   fail_in0,
    output logic [WIDTH-1:0]   fail_in1,
    output logic               fail_valid
);
    localparam int unsigned IW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        CHECK,
        FINISH
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [IW-1:0]    idx;
    logic [3:0]       settle_cnt;
    logic [WIDTH-1:0] op0;
    logic [WIDTH-1:0] op1;
    logic             settled;
    logic             last_vec;
    logic             mismatch;

    assign op0      = idx[IW-1:WIDTH];
    assign op1      = idx[WIDTH-1:0];
    assign settled  = (settle_cnt == 4'(SETTLE - 1));
    assign last_vec = (idx == '1);

    assign cmp.dut_in0 = op0;
    assign cmp.dut_in1 = op1;

    // Any deviation counts once, including several flags high or none at all.
    assign mismatch = (cmp.dut_greater != (op0 > op1))
                   || (cmp.dut_smaller != (op0 < op1))
                   || (cmp.dut_equal   != (op0 == op1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = APPLY;
                end
            end
            APPLY: begin
                if (settled) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                state_nxt = last_vec ? FINISH : APPLY;
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx        <= '0;
            settle_cnt <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_in0   <= '0;
            fail_in1   <= '0;
            fail_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx        <= '0;
                        settle_cnt <= '0;
                        pass       <= 1'b0;
                        err_count  <= '0;
                        fail_in0   <= '0;
                        fail_in1   <= '0;
                        fail_valid <= 1'b0;
                    end
                end
                APPLY: begin
                    settle_cnt <= settled ? '0 : settle_cnt + 4'd1;
                end
                CHECK: begin
                    if (mismatch) begin
                        if (err_count != '1) begin
                            err_count <= err_count + 1'b1;
                        end
                        if (!fail_valid) begin
                            fail_in0   <= op0;
                            fail_in1   <= op1;
                            fail_valid <= 1'b1;
                        end
                    end
                    if (!last_vec) begin
                        idx <= idx + 1'b1;
                    end
                end
                FINISH: begin
                    // The final CHECK has already updated err_count by now.
                    done <= 1'b1;
                    pass <= (err_count == '0);
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_comparator_bist.sv
// Directed bench for comparator_bist: behavioural comparator with selectable faults,
// plus a second SETTLE=3 engine attached to a correct comparator.
module tb_comparator_bist;
    localparam int unsigned W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic start3 = 1'b0;
    int   mode = 0;  // 0 good, 1 greater stuck 1, 2 greater/smaller swapped, 3 equal stuck 0

    logic           busy, done, pass, fail_valid;
    logic [2*W:0]   err_count;
    logic [W-1:0]   fail_in0, fail_in1;

    logic           busy3, done3, pass3, fail_valid3;
    logic [2*W:0]   err_count3;
    logic [W-1:0]   fail_in0_3, fail_in1_3;

    int n_assert = 0;
    int n_fail   = 0;
    int n;
    int n_done;

    always #5 clk = ~clk;

    comparator_bist_if #(.WIDTH(W)) bus ();
    comparator_bist_if #(.WIDTH(W)) bus3 ();

    comparator_bist #(.WIDTH(W), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cmp(bus),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_in0(fail_in0), .fail_in1(fail_in1), .fail_valid(fail_valid)
    );

    comparator_bist #(.WIDTH(W), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .cmp(bus3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err_count3),
        .fail_in0(fail_in0_3), .fail_in1(fail_in1_3), .fail_valid(fail_valid3)
    );

    always_comb begin
        bus.dut_greater = (bus.dut_in0 > bus.dut_in1);
        bus.dut_smaller = (bus.dut_in0 < bus.dut_in1);
        bus.dut_equal   = (bus.dut_in0 == bus.dut_in1);
        case (mode)
            1: bus.dut_greater = 1'b1;
            2: begin
                bus.dut_greater = (bus.dut_in0 < bus.dut_in1);
                bus.dut_smaller = (bus.dut_in0 > bus.dut_in1);
            end
            3: bus.dut_equal = 1'b0;
            default: begin
            end
        endcase
    end

    assign bus3.dut_greater = (bus3.dut_in0 > bus3.dut_in1);
    assign bus3.dut_smaller = (bus3.dut_in0 < bus3.dut_in1);
    assign bus3.dut_equal   = (bus3.dut_in0 == bus3.dut_in1);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!done && cyc < 2000);
    endtask

    task automatic check_result(input string tag, input int exp_err,
                                input int exp_f0, input int exp_f1);
        check({tag, "_latency"}, n, 513);
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_pass"}, 32'(pass), (exp_err == 0) ? 1 : 0);
        check({tag, "_err_count"}, 32'(err_count), exp_err);
        check({tag, "_fail_valid"}, 32'(fail_valid), (exp_err == 0) ? 0 : 1);
        check({tag, "_fail_in0"}, 32'(fail_in0), exp_f0);
        check({tag, "_fail_in1"}, 32'(fail_in1), exp_f1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_pass", 32'(pass), 0);
        check("rst_err_count", 32'(err_count), 0);
        check("rst_fail_valid", 32'(fail_valid), 0);
        check("rst_dut_in0", 32'(bus.dut_in0), 0);
        check("rst_dut_in1", 32'(bus.dut_in1), 0);
        rst_n = 1'b1;

        // Correct comparator.
        mode = 0;
        pulse_start();
        check("good_busy_rise", 32'(busy), 1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("good_vec1_in0", 32'(bus.dut_in0), 0);
        check("good_vec1_in1", 32'(bus.dut_in1), 1);
        wait_done(n);
        n = n + 2;
        check_result("good", 0, 0, 0);
        @(posedge clk);
        #1;
        check("good_busy_after", 32'(busy), 0);
        check("good_done_pulse", 32'(done), 0);
        check("good_pass_held", 32'(pass), 1);

        mode = 1;
        pulse_start();
        wait_done(n);
        check_result("gt_stuck1", 136, 0, 0);

        mode = 2;
        pulse_start();
        wait_done(n);
        check_result("swapped", 240, 0, 1);

        mode = 3;
        pulse_start();
        wait_done(n);
        check_result("eq_stuck0", 16, 0, 0);

        mode = 0;
        pulse_start();
        check("rerun_err_cleared", 32'(err_count), 0);
        check("rerun_fail_cleared", 32'(fail_valid), 0);
        check("rerun_pass_cleared", 32'(pass), 0);
        wait_done(n);
        check_result("rerun", 0, 0, 0);

        // Reset in the middle of a failing run.
        mode = 1;
        pulse_start();
        repeat (50) @(posedge clk);
        #1;
        check("midrun_err_nonzero", 32'(err_count != 0), 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_err_count", 32'(err_count), 0);
        check("midrst_fail_valid", 32'(fail_valid), 0);
        check("midrst_fail_in1", 32'(fail_in1), 0);
        check("midrst_dut_in1", 32'(bus.dut_in1), 0);
        check("midrst_pass", 32'(pass), 0);
        n_done = 0;
        repeat (600) begin
            @(posedge clk);
            #1;
            if (done || busy) n_done++;
        end
        check("midrst_no_done", n_done, 0);

        mode = 0;
        pulse_start();
        wait_done(n);
        check_result("after_rst", 0, 0, 0);

        // Extra start while a run is in progress.
        pulse_start();
        n = 0;
        while (!done && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 99) begin
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
                n++;
            end
        end
        check_result("repulse", 0, 0, 0);

        // Start held high: a new run begins as soon as IDLE is re-entered.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        wait_done(n);
        check("held_latency", n, 513);
        check("held_pass", 32'(pass), 1);
        @(posedge clk);
        #1;
        check("held_restart_busy", 32'(busy), 1);
        check("held_restart_pass_clr", 32'(pass), 0);
        start = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // SETTLE=3 engine.
        @(negedge clk);
        start3 = 1'b1;
        @(posedge clk);
        #1;
        start3 = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done3 && n < 3000);
        check("settle3_latency", n, 1025);
        check("settle3_pass", 32'(pass3), 1);
        check("settle3_err_count", 32'(err_count3), 0);
        check("settle3_fail_valid", 32'(fail_valid3), 0);
        @(posedge clk);
        #1;
        check("settle3_busy_after", 32'(busy3), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
